multi_debouncer: RTL and testbench

- Parametrised multi-channel successor to the single-input button debouncer.
- Each channel synchronises an asynchronous, bouncy input and produces a stable debounced level.
- Each channel also produces one-cycle press (rise) and release (fall) pulses and a one-shot long-press pulse.
- Sits between board buttons/switches and the control FSMs. All outputs are registered in the `clk` domain.

---
 rtl/multi_debouncer_pkg.sv | 18 +
 rtl/debounce_channel.sv | 97 +++++++++
 rtl/multi_debouncer.sv | 47 ++++
 tb/tb_multi_debouncer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_debouncer_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } dbc_state_e;

  // True when a CNT_W-bit counter can hold both terminal counts.
  function automatic bit cnt_fits(input int cnt_w, input int stable_cycles,
                                  input int long_cycles);
    longint cap;
    cap = (longint'(1) << cnt_w) - 1;
    return (longint'(stable_cycles) <= cap) && (longint'(long_cycles) <= cap);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser, stability filter, level, press/hold FSM
// and registered rise/fall/long_press pulses.
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 30,
  parameter int LONG_CYCLES   = 1000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  output logic debounced,
  output logic rise,
  output logic fall,
  output logic long_press
);

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CNT_W-1:0]       stab;
  logic [CNT_W-1:0]       hold;
  logic                   level;
  logic                   flip;
  dbc_state_e             state;

  assign s         = sync[SYNC_STAGES-1];
  assign flip      = (s != level) && (stab == STAB_LAST);
  assign debounced = level;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= '0;
      stab       <= '0;
      hold       <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;
      state      <= IDLE;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], noisy};
      rise       <= 1'b0;
      fall       <= 1'b0;
      long_press <= 1'b0;

      // Any sample agreeing with the level restarts the count, so bounces
      // never accumulate.
      if (s == level) begin
        stab <= '0;
      end else if (flip) begin
        stab  <= '0;
        level <= ~level;
        rise  <= ~level;
        fall  <= level;
      end else begin
        stab <= stab + 1'b1;
      end

      case (state)
        IDLE: begin
          if (flip && !level) begin
            state <= PRESSED;
            hold  <= '0;
          end
        end
        PRESSED: begin
          // A release on the terminal cycle wins: no long_press for it.
          if (flip && level) begin
            state <= IDLE;
            hold  <= '0;
          end else if (hold == HOLD_LAST) begin
            long_press <= 1'b1;
            state      <= HELD;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        HELD: begin
          if (flip && level) begin
            state <= IDLE;
            hold  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          hold  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: CHANNELS independent debounce_channel
// instances with an elaboration-time counter width check.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 30,
  parameter int LONG_CYCLES   = 1000,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] debounced,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] long_press
);

  if (!cnt_fits(CNT_W, STABLE_CYCLES, LONG_CYCLES)) begin : g_cnt_check
    $error("multi_debouncer: CNT_W too narrow for STABLE_CYCLES/LONG_CYCLES");
  end

  if ((SYNC_STAGES < 2) || (STABLE_CYCLES < 2) || (LONG_CYCLES <= STABLE_CYCLES))
  begin : g_param_check
    $error("multi_debouncer: invalid SYNC_STAGES/STABLE_CYCLES/LONG_CYCLES");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .noisy     (noisy[i]),
      .debounced (debounced[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .long_press(long_press[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed testbench for multi_debouncer (4 channels, 2 sync, stable 4, long 20).
module tb_multi_debouncer;

  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] noisy;
  logic [CH-1:0] debounced, rise, fall, long_press;

  int total = 0;
  int bad   = 0;

  multi_debouncer #(
    .CHANNELS(CH), .SYNC_STAGES(2), .STABLE_CYCLES(4), .LONG_CYCLES(20), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .noisy(noisy), .debounced(debounced),
    .rise(rise), .fall(fall), .long_press(long_press)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    noisy = '0;
    tick();
    tick();
    total++;
    if ({debounced, rise, fall, long_press} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0000", {debounced, rise, fall, long_press});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_clean_press();
    noisy[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (debounced !== ((k >= 6) ? 4'b0001 : 4'b0000) ||
          rise !== ((k == 6) ? 4'b0001 : 4'b0000) || fall !== 4'b0000) begin
        bad++;
        $display("FAIL clean_press k=%0d: deb=%b rise=%b fall=%b", k, debounced, rise, fall);
      end
    end
    noisy[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (debounced !== ((k < 6) ? 4'b0001 : 4'b0000) ||
          fall !== ((k == 6) ? 4'b0001 : 4'b0000) || rise !== 4'b0000 ||
          long_press !== 4'b0000) begin
        bad++;
        $display("FAIL clean_release k=%0d: deb=%b fall=%b rise=%b lp=%b",
                 k, debounced, fall, rise, long_press);
      end
    end
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 20; k++) begin
      noisy[1] = ((k % 4) < 2);
      tick();
      total++;
      if (debounced !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000) begin
        bad++;
        $display("FAIL bounce k=%0d: deb=%b rise=%b fall=%b", k, debounced, rise, fall);
      end
    end
    noisy[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (debounced !== ((k >= 6) ? 4'b0010 : 4'b0000) ||
          rise !== ((k == 6) ? 4'b0010 : 4'b0000)) begin
        bad++;
        $display("FAIL bounce_settle k=%0d: deb=%b rise=%b", k, debounced, rise);
      end
    end
  endtask

  task automatic test_glitch();
    // High glitch of 3 cycles while low
    noisy[2] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) noisy[2] = 1'b0;
      tick();
      total++;
      if (debounced[2] !== 1'b0 || rise[2] !== 1'b0 || fall[2] !== 1'b0) begin
        bad++;
        $display("FAIL glitch_high k=%0d: deb=%b rise=%b fall=%b",
                 k, debounced[2], rise[2], fall[2]);
      end
    end
    noisy[2] = 1'b1;
    for (int k = 1; k <= 6; k++) tick();
    total++;
    if (debounced[2] !== 1'b1 || rise[2] !== 1'b1) begin
      bad++;
      $display("FAIL glitch_setup: deb=%b rise=%b want 1 1", debounced[2], rise[2]);
    end
    // Low glitch of 3 cycles while high
    noisy[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) noisy[2] = 1'b1;
      tick();
      total++;
      if (debounced[2] !== 1'b1 || rise[2] !== 1'b0 || fall[2] !== 1'b0) begin
        bad++;
        $display("FAIL glitch_low k=%0d: deb=%b rise=%b fall=%b",
                 k, debounced[2], rise[2], fall[2]);
      end
    end
    noisy[2] = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    total++;
    if (debounced[2] !== 1'b0 || fall[2] !== 1'b1) begin
      bad++;
      $display("FAIL glitch_cleanup: deb=%b fall=%b want 0 1", debounced[2], fall[2]);
    end
  endtask

  task automatic test_long_press();
    noisy[3] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      total++;
      if (debounced[3] !== (k >= 6) || rise[3] !== (k == 6) ||
          long_press[3] !== (k == 26) || fall[3] !== 1'b0) begin
        bad++;
        $display("FAIL long_hold k=%0d: deb=%b rise=%b lp=%b fall=%b",
                 k, debounced[3], rise[3], long_press[3], fall[3]);
      end
    end
    noisy[3] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total++;
      if (debounced[3] !== (k < 6) || fall[3] !== (k == 6) || long_press[3] !== 1'b0) begin
        bad++;
        $display("FAIL long_release k=%0d: deb=%b fall=%b lp=%b",
                 k, debounced[3], fall[3], long_press[3]);
      end
    end
    noisy[3] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 11) noisy[3] = 1'b0;
      tick();
      total++;
      if (debounced[3] !== ((k >= 6) && (k < 16)) || rise[3] !== (k == 6) ||
          fall[3] !== (k == 16) || long_press[3] !== 1'b0) begin
        bad++;
        $display("FAIL short_press k=%0d: deb=%b rise=%b fall=%b lp=%b",
                 k, debounced[3], rise[3], fall[3], long_press[3]);
      end
    end
  endtask

  task automatic test_simultaneous();
    noisy[0] = 1'b1;
    noisy[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (rise !== ((k == 6) ? 4'b0001 : 4'b0000) ||
          fall !== ((k == 6) ? 4'b0010 : 4'b0000) ||
          debounced !== ((k >= 6) ? 4'b0001 : 4'b0010)) begin
        bad++;
        $display("FAIL simultaneous k=%0d: rise=%b fall=%b deb=%b", k, rise, fall, debounced);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    tick();
    rst = 1'b1;
    tick();
    total++;
    if ({debounced, rise, fall, long_press} !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid_hold: got %h want 0000", {debounced, rise, fall, long_press});
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      total++;
      if (debounced !== ((k >= 6) ? 4'b0001 : 4'b0000) ||
          rise !== ((k == 6) ? 4'b0001 : 4'b0000) || fall !== 4'b0000) begin
        bad++;
        $display("FAIL reset_recover k=%0d: deb=%b rise=%b fall=%b", k, debounced, rise, fall);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    noisy = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
